// File: rtl/sd_sector_buffer_bridge.sv
// rtl/sd_sector_buffer_bridge.sv - host-side sector buffer and command bridge in front of the SD controller
// Holds a dual-ported sector buffer and sequences one read/write command at a time into the controller.
module sd_sector_buffer_bridge #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SECTOR_BYTES   = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_host_cmd_valid,
    output logic        o_host_cmd_ready,
    input  logic        i_host_cmd_write,
    input  logic [31:0] i_host_sector,
    input  logic        i_host_buf_we,
    input  logic [8:0]  i_host_buf_addr,
    input  logic [7:0]  i_host_buf_wdata,
    output logic [7:0]  o_host_buf_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_status,
    output logic        o_busy,
    output logic [7:0]  o_controlreg,
    output logic [31:0] o_sd_addr,
    output logic [7:0]  o_sd_data,
    input  logic [7:0]  i_sd_data,
    input  logic [31:0] i_sd_addr,
    input  logic        i_sd_wr_nrd,
    input  logic        i_sd_req,
    input  logic [7:0]  i_sd_statusreg,
    input  logic        i_sd_write_statusreg
);
    localparam int AW = $clog2(SECTOR_BYTES);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] CTRL_NOP   = 8'd0;
    localparam logic [7:0] CTRL_READ  = 8'd1;
    localparam logic [7:0] CTRL_WRITE = 8'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    mem [SECTOR_BYTES];
    logic          active;
    logic [AW-1:0] host_idx;
    logic [AW-1:0] sd_idx;
    logic          unused_sd_addr_hi;

    assign active            = (state == ISSUE) || (state == WAIT_DONE);
    assign host_idx          = i_host_buf_addr[AW-1:0];
    assign sd_idx            = i_sd_addr[AW-1:0];
    assign unused_sd_addr_hi = ^i_sd_addr[31:AW];

    // Host and controller writes never overlap: host writes need !busy, controller writes need an active op.
    always_ff @(posedge i_clk) begin
        if (i_host_buf_we && !o_busy)
            mem[host_idx] <= i_host_buf_wdata;
        else if (active && i_sd_req && i_sd_wr_nrd)
            mem[sd_idx] <= i_sd_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_host_buf_rdata <= 8'h00;
            o_sd_data        <= 8'h00;
        end else begin
            o_host_buf_rdata <= mem[host_idx];
            o_sd_data        <= mem[sd_idx];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            tmo_cnt          <= '0;
            o_controlreg     <= CTRL_NOP;
            o_sd_addr        <= 32'h0;
            o_status         <= 8'h00;
            o_err            <= 1'b0;
            o_done           <= 1'b0;
            o_busy           <= 1'b0;
            o_host_cmd_ready <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_host_cmd_valid) begin
                        o_sd_addr        <= i_host_sector;
                        o_controlreg     <= i_host_cmd_write ? CTRL_WRITE : CTRL_READ;
                        o_err            <= 1'b0;
                        o_busy           <= 1'b1;
                        o_host_cmd_ready <= 1'b0;
                        hold_cnt         <= '0;
                        tmo_cnt          <= '0;
                        state            <= ISSUE;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    // The status strobe is checked before the timeout so a last-cycle strobe still succeeds.
                    if (i_sd_write_statusreg) begin
                        o_status     <= i_sd_statusreg;
                        o_err        <= (i_sd_statusreg != 8'h00);
                        o_controlreg <= CTRL_NOP;
                        o_done       <= 1'b1;
                        state        <= FINISH;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        o_status     <= 8'hFF;
                        o_err        <= 1'b1;
                        o_controlreg <= CTRL_NOP;
                        o_done       <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == ISSUE) begin
                            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                                o_controlreg <= CTRL_NOP;
                                state        <= WAIT_DONE;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    o_busy           <= 1'b0;
                    o_host_cmd_ready <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_buffer_bridge.sv
// tb/tb_sd_sector_buffer_bridge.sv - self-checking bench for sd_sector_buffer_bridge
module tb_sd_sector_buffer_bridge;
    localparam int HOLD = 4;
    localparam int TMO  = 64;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_host_cmd_valid = 1'b0;
    logic        o_host_cmd_ready;
    logic        i_host_cmd_write = 1'b0;
    logic [31:0] i_host_sector = 32'h0;
    logic        i_host_buf_we = 1'b0;
    logic [8:0]  i_host_buf_addr = 9'h0;
    logic [7:0]  i_host_buf_wdata = 8'h0;
    logic [7:0]  o_host_buf_rdata;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_status;
    logic        o_busy;
    logic [7:0]  o_controlreg;
    logic [31:0] o_sd_addr;
    logic [7:0]  o_sd_data;
    logic [7:0]  i_sd_data = 8'h0;
    logic [31:0] i_sd_addr = 32'h0;
    logic        i_sd_wr_nrd = 1'b0;
    logic        i_sd_req = 1'b0;
    logic [7:0]  i_sd_statusreg = 8'h0;
    logic        i_sd_write_statusreg = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mem_m [512];

    typedef struct {
        bit          wr;
        logic [31:0] sector;
        int          strobe_at;
        logic [7:0]  st;
        int          exp_done;
        logic [7:0]  exp_status;
        bit          exp_err;
        int          exp_len;
    } vec_t;
    vec_t vecs [10];

    sd_sector_buffer_bridge #(
        .HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TMO),
        .SECTOR_BYTES(512)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_host_cmd_valid(i_host_cmd_valid),
        .o_host_cmd_ready(o_host_cmd_ready),
        .i_host_cmd_write(i_host_cmd_write),
        .i_host_sector(i_host_sector),
        .i_host_buf_we(i_host_buf_we),
        .i_host_buf_addr(i_host_buf_addr),
        .i_host_buf_wdata(i_host_buf_wdata),
        .o_host_buf_rdata(o_host_buf_rdata),
        .o_done(o_done),
        .o_err(o_err),
        .o_status(o_status),
        .o_busy(o_busy),
        .o_controlreg(o_controlreg),
        .o_sd_addr(o_sd_addr),
        .o_sd_data(o_sd_data),
        .i_sd_data(i_sd_data),
        .i_sd_addr(i_sd_addr),
        .i_sd_wr_nrd(i_sd_wr_nrd),
        .i_sd_req(i_sd_req),
        .i_sd_statusreg(i_sd_statusreg),
        .i_sd_write_statusreg(i_sd_write_statusreg)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outcome of one command from the rules alone: strobe index k (cycles after issue) or none.
    task automatic model_op(input int strobe_at, input logic [7:0] st,
                            output int done, output logic [7:0] status, output bit err, output int len);
        if (strobe_at >= 0 && strobe_at < TMO) begin
            done = strobe_at + 1;
            status = st;
            err = (st != 8'h00);
        end else begin
            done = TMO;
            status = 8'hFF;
            err = 1'b1;
        end
        len = (done < HOLD) ? done : HOLD;
    endtask

    task automatic host_write(input logic [8:0] a, input logic [7:0] d);
        i_host_buf_we = 1'b1;
        i_host_buf_addr = a;
        i_host_buf_wdata = d;
        mem_m[a] = d;
        @(posedge i_clk); #1;
        i_host_buf_we = 1'b0;
    endtask

    task automatic host_read_chk(input logic [8:0] a);
        i_host_buf_addr = a;
        @(posedge i_clk);
        @(negedge i_clk);
        chk($sformatf("host_rd[%0d]", a), 32'(o_host_buf_rdata), 32'(mem_m[a]));
        @(posedge i_clk); #1;
    endtask

    task automatic sd_read_chk(input logic [31:0] a);
        i_sd_addr = a;
        i_sd_req = 1'b1;
        i_sd_wr_nrd = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk($sformatf("sd_rd[%0h]", a), 32'(o_sd_data), 32'(mem_m[a[8:0]]));
        @(posedge i_clk); #1;
        i_sd_req = 1'b0;
    endtask

    task automatic clear_inputs();
        i_sd_req = 1'b0;
        i_sd_wr_nrd = 1'b0;
        i_sd_write_statusreg = 1'b0;
        i_host_buf_we = 1'b0;
        i_host_cmd_valid = 1'b0;
    endtask

    // Issues one command and follows it cycle by cycle until o_done; optionally the controller
    // writes the buffer (pattern ~k or random, possibly wrapping addresses) and the host pokes at cycle 5.
    task automatic do_op(input string tag, input bit wr, input logic [31:0] sec, input int strobe_at,
                         input logic [7:0] st, input int n_sdw, input bit pat, input bit poke,
                         input int exp_done, input logic [7:0] exp_status, input bit exp_err, input int exp_len);
        int done_cyc;
        int clen;
        logic [7:0] cval;
        logic [31:0] aseen;
        logic [31:0] a;
        logic [7:0] d;
        done_cyc = -1;
        clen = 0;
        cval = 8'h00;
        aseen = 32'h0;
        i_host_cmd_valid = 1'b1;
        i_host_cmd_write = wr;
        i_host_sector = sec;
        @(posedge i_clk); #1;
        for (int k = 0; k < 200; k++) begin
            clear_inputs();
            if (k < n_sdw) begin
                a = pat ? 32'(k) : $urandom;
                d = pat ? ~8'(k) : 8'($urandom);
                i_sd_req = 1'b1;
                i_sd_wr_nrd = 1'b1;
                i_sd_addr = a;
                i_sd_data = d;
                mem_m[a[8:0]] = d;
            end
            if (poke && k == 5) begin
                i_host_buf_we = 1'b1;
                i_host_buf_addr = 9'd0;
                i_host_buf_wdata = 8'hAA;
                i_host_cmd_valid = 1'b1;
                i_host_cmd_write = ~wr;
                i_host_sector = ~sec;
            end
            if (k == strobe_at) begin
                i_sd_write_statusreg = 1'b1;
                i_sd_statusreg = st;
            end
            @(negedge i_clk);
            if (k == 0) aseen = o_sd_addr;
            if (poke && k == 5) begin
                chk({tag, ":ready_while_busy"}, 32'(o_host_cmd_ready), 32'd0);
                chk({tag, ":busy_in_wait"}, 32'(o_busy), 32'd1);
            end
            if (o_controlreg != 8'h00) begin
                clen++;
                cval = o_controlreg;
            end
            if (o_done) begin
                done_cyc = k;
                break;
            end
            @(posedge i_clk); #1;
        end
        clear_inputs();
        chk({tag, ":done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, ":status"}, 32'(o_status), 32'(exp_status));
        chk({tag, ":err"}, 32'(o_err), 32'(exp_err));
        chk({tag, ":ready_at_done"}, 32'(o_host_cmd_ready), 32'd0);
        chk({tag, ":ctrl_len"}, 32'(clen), 32'(exp_len));
        chk({tag, ":ctrl_val"}, 32'(cval), wr ? 32'd2 : 32'd1);
        chk({tag, ":sd_addr"}, aseen, sec);
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, ":done_one_cycle"}, 32'(o_done), 32'd0);
        chk({tag, ":ready_after"}, 32'(o_host_cmd_ready), 32'd1);
        chk({tag, ":busy_after"}, 32'(o_busy), 32'd0);
        chk({tag, ":sd_addr_kept"}, o_sd_addr, sec);
        @(posedge i_clk); #1;
    endtask

    // Asserts reset between edges at cycle cyc of a fresh write command.
    task automatic reset_during(input string tag, input int cyc, input logic [7:0] ctrl_before);
        i_host_cmd_valid = 1'b1;
        i_host_cmd_write = 1'b1;
        i_host_sector = 32'h0000_0ABC;
        @(posedge i_clk); #1;
        i_host_cmd_valid = 1'b0;
        repeat (cyc) begin
            @(posedge i_clk); #1;
        end
        chk({tag, ":ctrl_before"}, 32'(o_controlreg), 32'(ctrl_before));
        chk({tag, ":busy_before"}, 32'(o_busy), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk({tag, ":ctrl_async"}, 32'(o_controlreg), 32'd0);
        chk({tag, ":busy_async"}, 32'(o_busy), 32'd0);
        chk({tag, ":err_async"}, 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, ":ready_after_release"}, 32'(o_host_cmd_ready), 32'd1);
        chk({tag, ":ctrl_after_release"}, 32'(o_controlreg), 32'd0);
        @(posedge i_clk); #1;
    endtask

    initial begin
        int ed;
        logic [7:0] es;
        bit ee;
        int el;
        bit wr;
        logic [31:0] sec;
        int sa;
        logic [7:0] st;
        int nsdw;
        logic [31:0] a;

        vecs[0] = '{1'b1, 32'h0000_0010, 10, 8'h00, 11, 8'h00, 1'b0, 4};
        vecs[1] = '{1'b0, 32'h0000_0020, 10, 8'h00, 11, 8'h00, 1'b0, 4};
        vecs[2] = '{1'b1, 32'h0000_0005,  7, 8'h04,  8, 8'h04, 1'b1, 4};
        vecs[3] = '{1'b0, 32'h0000_0006, -1, 8'h00, 64, 8'hFF, 1'b1, 4};
        vecs[4] = '{1'b0, 32'h0000_0007, 63, 8'h00, 64, 8'h00, 1'b0, 4};
        vecs[5] = '{1'b1, 32'h0000_0008,  1, 8'h00,  2, 8'h00, 1'b0, 2};
        vecs[6] = '{1'b0, 32'h0000_0009,  0, 8'h33,  1, 8'h33, 1'b1, 1};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF,  3, 8'h00,  4, 8'h00, 1'b0, 4};
        vecs[8] = '{1'b0, 32'h0000_0001,  4, 8'h80,  5, 8'h80, 1'b1, 4};
        vecs[9] = '{1'b1, 32'h0000_0002, 62, 8'h01, 63, 8'h01, 1'b1, 4};

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst:controlreg", 32'(o_controlreg), 32'd0);
        chk("rst:sd_addr", o_sd_addr, 32'd0);
        chk("rst:status", 32'(o_status), 32'd0);
        chk("rst:err", 32'(o_err), 32'd0);
        chk("rst:done", 32'(o_done), 32'd0);
        chk("rst:busy", 32'(o_busy), 32'd0);
        chk("rst:ready", 32'(o_host_cmd_ready), 32'd1);
        chk("rst:host_rdata", 32'(o_host_buf_rdata), 32'd0);
        chk("rst:sd_data", 32'(o_sd_data), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Write path: host fills buf[i] = i, controller reads every index (with wrapping upper bits).
        for (int i = 0; i < 512; i++) host_write(9'(i), 8'(i));
        do_op("write_path", 1'b1, 32'h0000_0010, 10, 8'h00, 0, 1'b0, 1'b0, 11, 8'h00, 1'b0, 4);
        for (int i = 0; i < 512; i++) begin
            a = (32'($urandom_range(0, 7)) << 9) | 32'(i);
            sd_read_chk(a);
        end

        // Read path: controller writes buf[i] = ~i during the op.
        do_op("read_path", 1'b0, 32'h0000_0020, 60, 8'h00, 60, 1'b1, 1'b0, 61, 8'h00, 1'b0, 4);
        for (int i = 0; i < 8; i++) host_read_chk(9'(i));
        chk("read_path:model_buf5", 32'(mem_m[5]), 32'hFA);

        do_op("busy_poke", 1'b1, 32'h0000_0030, 20, 8'h00, 0, 1'b0, 1'b1, 21, 8'h00, 1'b0, 4);
        host_read_chk(9'd0);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sector, vecs[i].strobe_at, vecs[i].st,
                  0, 1'b0, 1'b0, vecs[i].exp_done, vecs[i].exp_status, vecs[i].exp_err, vecs[i].exp_len);

        // Idle: status strobe and controller write must both be ignored.
        i_sd_write_statusreg = 1'b1;
        i_sd_statusreg = 8'h77;
        i_sd_req = 1'b1;
        i_sd_wr_nrd = 1'b1;
        i_sd_addr = 32'h0000_0007;
        i_sd_data = ~mem_m[7];
        @(posedge i_clk); #1;
        clear_inputs();
        @(negedge i_clk);
        chk("idle_strobe:status", 32'(o_status), 32'(vecs[9].exp_status));
        chk("idle_strobe:err", 32'(o_err), 32'(vecs[9].exp_err));
        chk("idle_strobe:busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        host_read_chk(9'd7);

        // Reset between edges while idle with o_err set.
        #2;
        i_rst = 1'b1;
        #1;
        chk("idle_rst:err_async", 32'(o_err), 32'd0);
        chk("idle_rst:status_async", 32'(o_status), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        reset_during("rst_issue", 1, 8'd2);
        reset_during("rst_wait", 10, 8'd0);
        for (int i = 0; i < 4; i++) host_read_chk(9'(i * 37));
        do_op("fresh", 1'b0, 32'h1234_5678, 15, 8'h00, 10, 1'b0, 1'b0, 16, 8'h00, 1'b0, 4);

        for (int i = 0; i < 14; i++) begin
            for (int j = 0; j < 3; j++) host_write(9'($urandom_range(0, 511)), 8'($urandom));
            wr = 1'($urandom_range(0, 1));
            sec = $urandom;
            sa = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(0, 70));
            st = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            model_op(sa, st, ed, es, ee, el);
            nsdw = int'($urandom_range(0, (ed - 1 < 20) ? ed - 1 : 20));
            do_op($sformatf("rnd%0d", i), wr, sec, sa, st, nsdw, 1'b0, 1'b0, ed, es, ee, el);
        end
        for (int i = 0; i < 512; i++) host_read_chk(9'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_sector_buffer_bridge.md
Name: sd_sector_buffer_bridge

Overview:
- Host-side front end that sits directly upstream of the SD card controller.
- Accepts sector read/write requests from the host bus and holds a 512-byte sector buffer, dual-ported between host and controller.
- Drives the controller's control register, sector address and write-data byte, and consumes its status, data and byte-address/wr_nrd/req outputs.
- Reports completion, error or timeout back to the host.

Parameters:
- HOLD_CYCLES, 4, number of cycles a read/write opcode is held on o_controlreg before it returns to no-op.
- TIMEOUT_CYCLES, 1048576, cycles allowed between command issue and the controller status strobe before the operation aborts.
- SECTOR_BYTES, 512, buffer depth; must be a power of two.

Ports:
- i_clk  in  1  single clock (the same clock as the SD controller FSM).
- i_rst  in  1  asynchronous, active-high reset.
- i_host_cmd_valid  in  1  host request strobe.
- o_host_cmd_ready  out  1  high only in IDLE.
- i_host_cmd_write  in  1  1 = write sector, 0 = read sector.
- i_host_sector  in  32  sector address.
- i_host_buf_we  in  1  host buffer write enable.
- i_host_buf_addr  in  9  host buffer byte index.
- i_host_buf_wdata  in  8  host write byte.
- o_host_buf_rdata  out  8  host read byte, 1-cycle latency.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky error flag for the last operation.
- o_status  out  8  last captured status byte.
- o_busy  out  1  high whenever not in IDLE.
- o_controlreg  out  8  0 = no-op, 1 = read, 2 = write.
- o_sd_addr  out  32  latched sector address.
- o_sd_data  out  8  buffer byte for the controller, 1-cycle latency.
- i_sd_data  in  8  byte from the controller (card read path).
- i_sd_addr  in  32  controller byte index; bits [8:0] used.
- i_sd_wr_nrd  in  1  1 = controller writes buffer, 0 = controller reads buffer.
- i_sd_req  in  1  controller buffer access qualifier.
- i_sd_statusreg  in  8  controller status byte.
- i_sd_write_statusreg  in  1  controller status-valid strobe.

Behaviour:
- Reset values: o_controlreg = 0, o_sd_addr = 0, o_status = 0, o_err = 0, o_done = 0, o_busy = 0, o_host_cmd_ready = 1, o_host_buf_rdata = 0, o_sd_data = 0, timeout and hold counters = 0, FSM = IDLE. Buffer contents are not reset.
- Reset mid-operation: all of the above apply immediately and o_controlreg drops to 0 asynchronously.
- Buffer port A (host):
  - Write when i_host_buf_we is high and o_busy is low.
  - Host writes while busy are ignored; host reads are always permitted.
- Buffer port B (controller):
  - Write i_sd_data when i_sd_req and i_sd_wr_nrd are both high, and only in states ISSUE or WAIT_DONE.
  - o_sd_data is registered from mem[i_sd_addr[8:0]] every cycle.
- Same-address collision: host writes are blocked while busy, so no collision is possible.
- FSM IDLE:
  - On i_host_cmd_valid, latch i_host_sector into o_sd_addr and latch the op.
  - Clear o_err and set o_busy.
  - Go to ISSUE; the handshake completes in that single cycle.
- FSM ISSUE:
  - o_controlreg = 2 for write, 1 for read.
  - Hold counter counts to HOLD_CYCLES-1, then go to WAIT_DONE.
- FSM WAIT_DONE:
  - o_controlreg = 0.
  - Timeout counter increments each cycle spent in ISSUE and WAIT_DONE.
- Completion:
  - i_sd_write_statusreg seen in ISSUE or WAIT_DONE: capture i_sd_statusreg into o_status.
  - Set o_err = (i_sd_statusreg != 0) and go to FINISH.
  - A strobe arriving during ISSUE also forces o_controlreg to 0 on the next cycle.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1, set o_status = 8'hFF and o_err = 1, then go to FINISH.
- Simultaneous strobe and timeout: the strobe wins.
- FSM FINISH: o_done = 1 for one cycle, o_busy = 0, return to IDLE.
- A new host request is accepted no earlier than the cycle after o_done.
- i_host_cmd_valid outside IDLE is ignored; it is not queued.
- Status strobes in IDLE are ignored, and o_status is unchanged.
- Address wrap: controller indices above 511 wrap via bits [8:0].

Test Plan:
- Write path: host fills buf[i] = i[7:0]; write command for sector 0x0000_0010.
  - o_controlreg = 2 for exactly 4 cycles; o_sd_addr = 0x10.
  - Controller reads indices 0..511 and gets o_sd_data = index[7:0] one cycle later.
  - Status 0x00 strobe → o_done pulse, o_err = 0.
- Read path: read command; controller writes buf[i] = ~i[7:0] with wr_nrd = 1; status 0x00 strobe.
  - Host reads addr 5 → 0xFA after 1 cycle.
  - o_controlreg = 1 for exactly 4 cycles.
- Error status: strobe with i_sd_statusreg = 0x04 → o_status = 0x04, o_err = 1, o_done pulses once.
- Timeout (TIMEOUT_CYCLES = 64): no strobe.
  - o_done pulses at cycle 64 after issue; o_status = 0xFF; o_err = 1.
  - A strobe at exactly cycle 63 instead yields o_err = 0.
- Busy protection: during WAIT_DONE, host writes buf[0] = 0xAA → buf[0] unchanged; a second i_host_cmd_valid is ignored and o_host_cmd_ready = 0.
- Async reset mid-WAIT_DONE: assert i_rst between clock edges.
  - o_controlreg, o_busy and o_err go to 0 immediately; o_host_cmd_ready = 1 after release.
  - A fresh command then completes normally.
